// File: rtl/dpll_freq_ctrl.sv
// Frequency-lock controller for the user-project DPLL.
// Counts clock cycles per reference period and compares the count with a
// target selected by freq_sel. It then steers a saturating DCO trim code in
// fine or coarse steps and reports acquire/track/lock status.
`timescale 1ns/1ps
module dpll_freq_ctrl #(
  parameter int CNT_W       = 8,
  parameter int TRIM_W      = 6,
  parameter int TRIM_INIT   = 2**(TRIM_W-1),
  parameter int DIV0        = 8,
  parameter int DIV1        = 16,
  parameter int DIV2        = 24,
  parameter int DIV3        = 32,
  parameter int TOL         = 1,
  parameter int COARSE_TH   = 4,
  parameter int COARSE_STEP = 4,
  parameter int LOCK_N      = 4,
  parameter int UNLOCK_N    = 2
) (
  input  logic              clock,
  input  logic              resetb,
  input  logic              enable,
  input  logic              ref_in,
  input  logic [1:0]        freq_sel,
  output logic [TRIM_W-1:0] trim,
  output logic [1:0]        status,
  output logic              lock,
  output logic [CNT_W-1:0]  meas
);

  localparam int LCK_W = $clog2(LOCK_N + 1);
  localparam int ULK_W = $clog2(UNLOCK_N + 1);
  localparam logic [LCK_W-1:0]       LOCK_MAX   = LCK_W'(LOCK_N);
  localparam logic [ULK_W-1:0]       UNLOCK_MAX = ULK_W'(UNLOCK_N);
  localparam logic signed [CNT_W:0]  TOL_S      = (CNT_W+1)'(TOL);
  localparam logic [CNT_W:0]         CTH_U      = (CNT_W+1)'(COARSE_TH);
  localparam logic [CNT_W:0]         TOL_U      = (CNT_W+1)'(TOL);
  localparam logic [TRIM_W-1:0]      STEP_C     = TRIM_W'(COARSE_STEP);
  localparam logic [TRIM_W-1:0]      STEP_F     = TRIM_W'(1);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_ACQ   = 2'b01;
  localparam logic [1:0] ST_TRACK = 2'b10;
  localparam logic [1:0] ST_LOCK  = 2'b11;

  typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, ADJUST} state_t;

  state_t state, state_nxt;

  logic ref_sync_p0, ref_sync_p1, ref_dly_p2, ref_edge_p3;
  logic [1:0] fsel_p0, fsel_p1;
  logic fsel_chg;

  logic [CNT_W-1:0]  cnt, cnt_nxt, meas_nxt, target;
  logic [TRIM_W-1:0] trim_nxt, step;
  logic [1:0]        status_nxt;
  logic [LCK_W-1:0]  in_cnt, in_nxt;
  logic [ULK_W-1:0]  out_cnt, out_nxt;

  logic signed [CNT_W:0] err;
  logic [CNT_W:0]        mag;
  logic                  meas_sat, in_band, too_fast, too_slow;

  function automatic logic [TRIM_W-1:0] trim_dec(input logic [TRIM_W-1:0] t,
                                                 input logic [TRIM_W-1:0] s);
    if (t < s) return '0;
    return t - s;
  endfunction

  function automatic logic [TRIM_W-1:0] trim_inc(input logic [TRIM_W-1:0] t,
                                                 input logic [TRIM_W-1:0] s);
    logic [TRIM_W:0] sum;
    sum = {1'b0, t} + {1'b0, s};
    if (sum[TRIM_W]) return '1;
    return sum[TRIM_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    if (c == '1) return c;
    return c + 1'b1;
  endfunction

  // Reference synchroniser, registered rising-edge detect and freq_sel capture
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      ref_sync_p0 <= 1'b0;
      ref_sync_p1 <= 1'b0;
      ref_dly_p2  <= 1'b0;
      ref_edge_p3 <= 1'b0;
      fsel_p0     <= 2'b00;
      fsel_p1     <= 2'b00;
    end else begin
      ref_sync_p0 <= ref_in;
      ref_sync_p1 <= ref_sync_p0;
      ref_dly_p2  <= ref_sync_p1;
      ref_edge_p3 <= ref_sync_p1 & ~ref_dly_p2;
      fsel_p0     <= freq_sel;
      fsel_p1     <= fsel_p0;
    end
  end

  assign fsel_chg = (fsel_p0 != fsel_p1);

  // Target count for the registered frequency select
  always_comb begin
    case (fsel_p0)
      2'd0:    target = CNT_W'(DIV0);
      2'd1:    target = CNT_W'(DIV1);
      2'd2:    target = CNT_W'(DIV2);
      default: target = CNT_W'(DIV3);
    endcase
  end

  // Period error and its classification; a saturated count always reads as fast
  always_comb begin
    err      = $signed({1'b0, meas}) - $signed({1'b0, target});
    mag      = err[CNT_W] ? $unsigned(-err) : $unsigned(err);
    meas_sat = (meas == '1);
    too_fast = meas_sat || (err > TOL_S);
    too_slow = !meas_sat && (err < -TOL_S);
    in_band  = !meas_sat && (mag <= TOL_U);
    step     = (meas_sat || (mag > CTH_U)) ? STEP_C : STEP_F;
  end

  // State register
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: enable dominates, then a target change restarts acquisition
  always_comb begin
    state_nxt = state;
    if (!enable)               state_nxt = IDLE;
    else if (state == IDLE)    state_nxt = WAIT_EDGE;
    else if (fsel_chg)         state_nxt = WAIT_EDGE;
    else begin
      case (state)
        WAIT_EDGE: if (ref_edge_p3) state_nxt = MEASURE;
        MEASURE:   if (ref_edge_p3) state_nxt = ADJUST;
        ADJUST:    state_nxt = MEASURE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // Output logic: counter, measurement, trim steering and lock bookkeeping
  always_comb begin
    cnt_nxt    = cnt;
    meas_nxt   = meas;
    trim_nxt   = trim;
    status_nxt = status;
    in_nxt     = in_cnt;
    out_nxt    = out_cnt;
    if (!enable) begin
      cnt_nxt    = '0;
      in_nxt     = '0;
      out_nxt    = '0;
      status_nxt = ST_IDLE;
    end else if (state == IDLE) begin
      cnt_nxt    = '0;
      status_nxt = ST_ACQ;
    end else if (fsel_chg) begin
      cnt_nxt    = '0;
      in_nxt     = '0;
      out_nxt    = '0;
      status_nxt = ST_ACQ;
    end else begin
      case (state)
        WAIT_EDGE: begin
          if (ref_edge_p3) cnt_nxt = CNT_W'(1);
        end
        MEASURE: begin
          if (ref_edge_p3) begin
            meas_nxt = cnt;
            cnt_nxt  = CNT_W'(1);
          end else begin
            cnt_nxt = cnt_inc(cnt);
          end
        end
        ADJUST: begin
          // Any reference edge here belongs to the period already being counted
          cnt_nxt = cnt_inc(cnt);
          if (too_fast)      trim_nxt = trim_dec(trim, step);
          else if (too_slow) trim_nxt = trim_inc(trim, step);
          if (in_band) begin
            out_nxt = '0;
            if (in_cnt != LOCK_MAX) in_nxt = in_cnt + 1'b1;
            status_nxt = (in_nxt == LOCK_MAX) ? ST_LOCK : ST_TRACK;
          end else if (status == ST_LOCK) begin
            out_nxt = out_cnt + 1'b1;
            if (out_nxt >= UNLOCK_MAX) begin
              status_nxt = ST_ACQ;
              in_nxt     = '0;
              out_nxt    = '0;
            end
          end else begin
            status_nxt = ST_ACQ;
            in_nxt     = '0;
            out_nxt    = '0;
          end
        end
        default: ;
      endcase
    end
  end

  // Output and datapath registers
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt     <= '0;
      meas    <= '0;
      trim    <= TRIM_W'(TRIM_INIT);
      status  <= ST_IDLE;
      lock    <= 1'b0;
      in_cnt  <= '0;
      out_cnt <= '0;
    end else begin
      cnt     <= cnt_nxt;
      meas    <= meas_nxt;
      trim    <= trim_nxt;
      status  <= status_nxt;
      lock    <= (status_nxt == ST_LOCK);
      in_cnt  <= in_nxt;
      out_cnt <= out_nxt;
    end
  end

endmodule

// File: tb/tb_dpll_freq_ctrl.sv
// Testbench for dpll_freq_ctrl: a timestamp-based model of the measurement
// loop is checked against the DUT every cycle, plus literal spot values.
`timescale 1ns/1ps
module tb_dpll_freq_ctrl;

  localparam int CNT_W  = 8;
  localparam int TRIM_W = 6;

  logic              clock;
  logic              resetb;
  logic              enable;
  logic              ref_in;
  logic [1:0]        freq_sel;
  logic [TRIM_W-1:0] trim;
  logic [1:0]        status;
  logic              lock;
  logic [CNT_W-1:0]  meas;

  int n_cmp;
  int n_bad;

  dpll_freq_ctrl dut (
    .clock    (clock),
    .resetb   (resetb),
    .enable   (enable),
    .ref_in   (ref_in),
    .freq_sel (freq_sel),
    .trim     (trim),
    .status   (status),
    .lock     (lock),
    .meas     (meas)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Edges are time-stamped in clock cycles; a measurement is the distance
  // between consecutive detected edges, detected 3 cycles after ref_in rises.
  int  div_tab [4] = '{8, 16, 24, 32};
  bit  rh [4];
  int  fh [2];
  int  pcount, prev_p, m_tgt;
  bit  m_run, m_have, m_adj, m_edge, m_chg;
  int  e_trim, e_status, e_meas, m_in, m_out;

  task automatic apply_adjust(input int tgt);
    int err, mag, stp;
    bit sat;
    sat = (e_meas == 255);
    err = e_meas - tgt;
    mag = (err < 0) ? -err : err;
    stp = (sat || mag > 4) ? 4 : 1;
    if (sat || err > 1)   e_trim = (e_trim - stp < 0) ? 0 : e_trim - stp;
    else if (err < -1)    e_trim = (e_trim + stp > 63) ? 63 : e_trim + stp;
    if (!sat && mag <= 1) begin
      m_out = 0;
      if (m_in < 4) m_in++;
      e_status = (m_in == 4) ? 3 : 2;
    end else if (e_status == 3) begin
      m_out++;
      if (m_out >= 2) begin
        e_status = 1; m_in = 0; m_out = 0;
      end
    end else begin
      e_status = 1; m_in = 0; m_out = 0;
    end
  endtask

  initial begin : model
    forever begin
      @(posedge clock or negedge resetb);
      if (!resetb) begin
        for (int k = 0; k < 4; k++) rh[k] = 1'b0;
        fh[0] = 0; fh[1] = 0;
        pcount = 0; prev_p = 0;
        m_run = 0; m_have = 0; m_adj = 0;
        e_trim = 32; e_status = 0; e_meas = 0; m_in = 0; m_out = 0;
      end else begin
        pcount++;
        m_edge = rh[2] && !rh[3];
        m_chg  = (fh[0] != fh[1]);
        m_tgt  = div_tab[fh[0]];
        rh[3] = rh[2]; rh[2] = rh[1]; rh[1] = rh[0]; rh[0] = ref_in;
        fh[1] = fh[0]; fh[0] = int'(freq_sel);
        if (!enable) begin
          m_run = 0; m_have = 0; m_adj = 0; m_in = 0; m_out = 0; e_status = 0;
        end else if (!m_run) begin
          m_run = 1; m_have = 0; m_adj = 0; e_status = 1;
        end else if (m_chg) begin
          m_have = 0; m_adj = 0; m_in = 0; m_out = 0; e_status = 1;
        end else if (m_adj) begin
          m_adj = 0;
          apply_adjust(m_tgt);
        end else if (m_edge) begin
          if (m_have) begin
            e_meas = (pcount - prev_p > 255) ? 255 : pcount - prev_p;
            m_adj  = 1;
          end
          prev_p = pcount;
          m_have = 1;
        end
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clock);
      check("trim",   int'(trim),   e_trim);
      check("status", int'(status), e_status);
      check("lock",   int'(lock),   (e_status == 3) ? 1 : 0);
      check("meas",   int'(meas),   e_meas);
    end
  end

  // ---------------- stimulus ----------------
  task automatic ref_run(input int period, input int count);
    for (int i = 0; i < count; i++) begin
      ref_in = 1'b1;
      repeat (period / 2) @(negedge clock);
      ref_in = 1'b0;
      repeat (period - period / 2) @(negedge clock);
    end
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  int tr_seen [12];
  int per;

  initial begin : stim
    n_cmp = 0; n_bad = 0;
    resetb = 1'b0; enable = 1'b0; ref_in = 1'b0; freq_sel = 2'd1;
    repeat (3) @(negedge clock);
    #1;
    check("rst_trim",   int'(trim),   32);
    check("rst_status", int'(status), 0);
    check("rst_lock",   int'(lock),   0);
    check("rst_meas",   int'(meas),   0);
    @(negedge clock);
    resetb = 1'b1;
    repeat (3) @(negedge clock);

    // nominal acquisition at target 16
    enable = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    check("nom_acq_status", int'(status), 1);
    ref_run(16, 2);
    check("nom_track_status", int'(status), 2);
    ref_run(16, 5);
    check("nom_lock_status", int'(status), 3);
    check("nom_lock",        int'(lock),   1);
    check("nom_trim",        int'(trim),   32);
    check("nom_meas",        int'(meas),   16);

    // unlock hysteresis
    ref_run(24, 1);
    ref_run(24, 1);
    check("unlk1_status", int'(status), 3);
    check("unlk1_trim",   int'(trim),   28);
    ref_run(16, 1);
    check("unlk2_status", int'(status), 1);
    check("unlk2_lock",   int'(lock),   0);
    check("unlk2_trim",   int'(trim),   24);
    ref_run(16, 6);
    check("relock", int'(lock), 1);

    // mode change to target 32
    freq_sel = 2'd3;
    repeat (2) @(negedge clock);
    #1;
    check("mode_status", int'(status), 1);
    check("mode_trim",   int'(trim),   24);
    ref_run(32, 7);
    check("mode_lock", int'(lock), 1);
    check("mode_meas", int'(meas), 32);
    check("mode_trim2", int'(trim), 24);

    // asynchronous reset in the middle of a measurement
    repeat (10) @(negedge clock);
    @(posedge clock);
    #2;
    resetb = 1'b0;
    enable = 1'b0;
    #1;
    check("arst_trim",   int'(trim),   32);
    check("arst_status", int'(status), 0);
    check("arst_lock",   int'(lock),   0);
    check("arst_meas",   int'(meas),   0);
    freq_sel = 2'd1;
    @(negedge clock);
    resetb = 1'b1;
    repeat (3) @(negedge clock);
    enable = 1'b1;
    @(negedge clock);

    // coarse/fine steering with a DCO whose ref period in clocks is trim-2
    for (int k = 0; k < 12; k++) begin
      ref_in = 1'b1;
      repeat (4) @(negedge clock);
      ref_in = 1'b0;
      repeat (4) @(negedge clock);
      tr_seen[k] = int'(trim);
      per = int'(trim) - 2;
      if (per < 10) per = 10;
      repeat (per - 8) @(negedge clock);
    end
    check("steer_t0", tr_seen[0], 32);
    check("steer_t1", tr_seen[1], 28);
    check("steer_t2", tr_seen[2], 24);
    check("steer_t3", tr_seen[3], 20);
    check("steer_t4", tr_seen[4], 19);
    check("steer_lock", int'(lock), 1);
    check("steer_meas", int'(meas), 17);

    // enable low holds trim, re-enable restarts acquisition
    enable = 1'b0;
    settle();
    check("dis_status", int'(status), 0);
    check("dis_trim",   int'(trim),   19);
    repeat (5) @(negedge clock);
    enable = 1'b1;
    settle();
    check("reen_status", int'(status), 1);
    ref_run(16, 6);
    check("reen_lock", int'(lock), 1);
    check("reen_meas", int'(meas), 16);

    // saturated measurement drives trim to zero
    ref_run(300, 8);
    check("sat_meas",   int'(meas),   255);
    check("sat_trim",   int'(trim),   0);
    check("sat_status", int'(status), 1);
    repeat (600) @(negedge clock);
    #1;
    check("stall_trim",   int'(trim),   0);
    check("stall_status", int'(status), 1);

    @(negedge clock);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dpll_freq_ctrl.md
# dpll_freq_ctrl

Parametrised frequency-lock controller for the user-project DPLL. It counts `clock` cycles per period of an external reference on `ref_in` and compares the count against a target ratio chosen by `freq_sel`. It steers a saturating DCO trim code in fine or coarse steps and reports acquisition and lock on a 2-bit status bus driven to GPIO.

## Interface
Parameters:
- `CNT_W`, 8: period counter / measurement width.
- `TRIM_W`, 6: trim code width.
- `TRIM_INIT`, 2**(TRIM_W-1): trim reset value (midscale).
- `DIV0`..`DIV3`, 8/16/24/32: target cycles per reference period for `freq_sel` = 0..3.
- `TOL`, 1: in-band tolerance, in cycles.
- `COARSE_TH`, 4: error above which a coarse step is used.
- `COARSE_STEP`, 4: coarse trim step.
- `LOCK_N`, 4: consecutive in-band measurements needed to assert lock.
- `UNLOCK_N`, 2: consecutive out-of-band measurements needed to drop lock.

Ports:
- `clock` in 1: DCO-derived system clock; all logic on rising edge.
- `resetb` in 1: asynchronous, active-low reset.
- `enable` in 1: run loop; low forces IDLE, trim held.
- `ref_in` in 1: asynchronous reference clock.
- `freq_sel` in 2: target select; quasi-static.
- `trim` out TRIM_W: DCO trim code.
- `status` out 2: 00 idle, 01 acquiring, 10 tracking, 11 locked.
- `lock` out 1: equals `status == 2'b11`.
- `meas` out CNT_W: last completed period count.

## Operation
- `ref_in` passes through a 2-flop synchroniser and a registered rising-edge detector, giving a 1-cycle `ref_edge`.
- States: IDLE, WAIT_EDGE, MEASURE, ADJUST.
- IDLE: entered on reset or `enable` low. `status`=00. Counters cleared; `trim` holds its value. `enable` high -> WAIT_EDGE.
- WAIT_EDGE: `status`=01. On `ref_edge`: cnt<=1 -> MEASURE. Discards the partial first period.
- MEASURE: cnt increments each cycle and saturates at 2**CNT_W-1. On `ref_edge`: meas<=cnt, cnt<=1 -> ADJUST.
- ADJUST, one cycle: cnt keeps counting. Compute err = meas - target as signed CNT_W+1 bits. Then -> MEASURE.
  - If |err| <= TOL: in-band.
  - If err > TOL (DCO fast): trim -= step.
  - If err < -TOL: trim += step.
  - step = COARSE_STEP if |err| > COARSE_TH, else 1.
  - Trim saturates at 0 and at 2**TRIM_W-1; it never wraps.
- A saturated count is out-of-band fast (err positive).
- Status (updated in ADJUST):
  - In-band: out-of-band counter cleared, in-band counter incremented. Status becomes 10 if below LOCK_N and 11 at LOCK_N; the in-band counter saturates.
  - Out-of-band while locked: out-of-band counter incremented; at UNLOCK_N, status becomes 01 and the in-band counter clears.
  - Out-of-band while not locked: status becomes 01 and the in-band counter clears.
- `freq_sel` is registered every cycle. A change seen outside IDLE clears the lock counters, sets status 01 and moves to WAIT_EDGE. `trim` is retained.
- A `ref_edge` during ADJUST is ignored and counted as part of the next period. The minimum legal reference period is 4 `clock` cycles.
- `enable` low in any state -> IDLE next cycle; a measurement in progress is discarded.

## Timing
- Reset values: `trim`=TRIM_INIT, `status`=00, `lock`=0, `meas`=0, state IDLE.
- From a `ref_in` rise to `ref_edge`: 3 cycles.
- From `ref_edge` to `meas` valid: 1 cycle.
- From `ref_edge` to `trim`/`status` updated: 2 cycles.
- `meas` equals the exact number of `clock` rising edges between consecutive detected edges, so a period of D clocks gives meas=D.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `resetb` assertion forces the reset values immediately, asynchronously. Deassertion is assumed synchronised externally.

## Test plan
- **Nominal acquisition:** reset, enable=1, freq_sel=1 (target 16), ref period = 16 clocks.
  - Status goes 00 -> 01 -> 10 after the first in-band measurement, then 11 after the 4th.
  - trim stays 32 and meas=16.
- **Coarse/fine steering:** behavioural DCO model whose period ratio depends on trim, starting with meas=30 against target 16.
  - First adjustments step by 4, then by 1 once |err| <= 4.
  - Lock is reached and trim is monotonic in direction.
- **Saturation:** ref period of 300 clocks with CNT_W=8, so meas=255.
  - trim decrements to 0 and stays 0.
  - With the ref stalled (no edges), status stays at its last value and trim does not change.
- **Unlock hysteresis:** from locked, inject one out-of-band period -> status remains 11. Inject a second consecutive one -> status 01 and lock=0.
- **Mode change:** while locked at freq_sel=1, switch to freq_sel=3.
  - Within 2 cycles status=01 and trim is unchanged.
  - The next partial period is discarded; the loop retargets to 32.
- **Reset/enable mid-operation:**
  - resetb low during MEASURE -> outputs equal their reset values in the same cycle.
  - enable low -> status 00 on the next cycle and trim held. Re-enabling restarts from WAIT_EDGE.
